// File: rtl/ram_block_copier.sv
// rtl/ram_block_copier.sv - block copy initiator for a 1W/2R word RAM (option: RAM_BLOCK_COPIER_CHECKSUM_EN)
module ram_block_copier #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 9
) (
    input  logic              signal_C,
    input  logic              signal_R,
    input  logic              signal_S,
    input  logic [ADDR_W-1:0] signal_1_1,
    input  logic [ADDR_W-1:0] signal_1_2,
    input  logic [LEN_W-1:0]  signal_L,
    output logic [ADDR_W-1:0] signal_Q,
    input  logic [DATA_W-1:0] signal_V,
    output logic [ADDR_W-1:0] signal_A,
    output logic [DATA_W-1:0] signal_D,
    output logic              signal_E,
    output logic              signal_B,
    output logic              signal_F
`ifdef RAM_BLOCK_COPIER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] signal_K
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COPY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  k;
    logic              last_read;
    logic              start_ok;

    // k counts reads; the read of word len-1 ends the COPY phase
    assign last_read = (k == len_r - LEN_W'(1));
    assign start_ok  = (state == IDLE) && signal_S;
    assign signal_B  = (state != IDLE);
    assign signal_F  = (state == DONE);

    // FSM plus read/write pipeline; the read pointer lives directly in signal_Q
    always_ff @(posedge signal_C) begin
        if (signal_R) begin
            state    <= IDLE;
            dst_r    <= '0;
            len_r    <= '0;
            k        <= '0;
            signal_Q <= '0;
            signal_A <= '0;
            signal_D <= '0;
            signal_E <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (signal_S) begin
                        if (signal_L != '0) begin
                            state    <= COPY;
                            signal_Q <= signal_1_1;
                            dst_r    <= signal_1_2;
                            len_r    <= signal_L;
                            k        <= '0;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                COPY: begin
                    // word k is captured now and written next cycle, overlapping read k+1
                    signal_D <= signal_V;
                    signal_A <= dst_r + k[ADDR_W-1:0];
                    signal_E <= 1'b1;
                    if (last_read) begin
                        state <= DRAIN;
                    end else begin
                        k        <= k + LEN_W'(1);
                        signal_Q <= signal_Q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    signal_E <= 1'b0;
                    state    <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_BLOCK_COPIER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    assign signal_K = sum;

    // running sum of the words being copied; every captured word is written one cycle later
    always_ff @(posedge signal_C) begin
        if (signal_R) begin
            sum <= '0;
        end else if (start_ok) begin
            sum <= '0;
        end else if (state == COPY) begin
            sum <= sum + signal_V;
        end
    end
`endif

endmodule

// File: tb/tb_ram_block_copier.sv
// tb/tb_ram_block_copier.sv - randomized self-checking bench for ram_block_copier
module tb_ram_block_copier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [8:0]  len;
    logic [7:0]  q;
    logic [31:0] v;
    logic [7:0]  a;
    logic [31:0] d;
    logic        e;
    logic        b;
    logic        f;
`ifdef RAM_BLOCK_COPIER_CHECKSUM_EN
    logic [31:0] k_out;
`endif

    logic [31:0] ram [256];
    logic [31:0] ref_mem [256];
    logic        pre_we;
    logic [7:0]  pre_a;
    logic [31:0] pre_d;

    int checks = 0;
    int errors = 0;

    int obs_e, obs_f, obs_f_cycle, obs_first_e, obs_busy, obs_gap, obs_timeout;
    logic [31:0] obs_k;
    logic [31:0] exp_sum;

    always #5 clk = ~clk;

    ram_block_copier dut (
        .signal_C   (clk),
        .signal_R   (rst),
        .signal_S   (start),
        .signal_1_1 (src),
        .signal_1_2 (dst),
        .signal_L   (len),
        .signal_Q   (q),
        .signal_V   (v),
        .signal_A   (a),
        .signal_D   (d),
        .signal_E   (e),
        .signal_B   (b),
        .signal_F   (f)
`ifdef RAM_BLOCK_COPIER_CHECKSUM_EN
        ,
        .signal_K   (k_out)
`endif
    );

    assign v = ram[q];

    always @(posedge clk) begin
        if (pre_we) ram[pre_a] <= pre_d;
        else if (e) ram[a] <= d;
    end

    task automatic poke(input int addr, input logic [31:0] val);
        pre_we = 1'b1;
        pre_a = addr[7:0];
        pre_d = val;
        ref_mem[addr & 255] = val;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic fill_random;
        for (int i = 0; i < 256; i++) poke(i, $urandom);
    endtask

    function automatic int ram_diff();
        int n = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Forward copy with the read of word k happening before write k-1 lands.
    task automatic model_copy(input int s, input int dd, input int l, input int nw);
        logic [31:0] vals [257];
        exp_sum = 32'd0;
        for (int i = 0; i <= l; i++) begin
            if (i < l) begin
                vals[i] = ref_mem[(s + i) & 255];
                exp_sum = exp_sum + vals[i];
            end
            if (i >= 1 && (i - 1) < nw) ref_mem[(dd + i - 1) & 255] = vals[i-1];
        end
    endtask

    task automatic run_copy(input int s, input int dd, input int l, input int glitch);
        int last_e;
        bit seen_f;
        obs_e = 0; obs_f = 0; obs_f_cycle = -1; obs_first_e = -1; obs_busy = 0;
        obs_gap = 0; obs_timeout = 1; last_e = -1; seen_f = 0; obs_k = 32'd0;
        src = s[7:0]; dst = dd[7:0]; len = l[8:0]; start = 1'b1;
        for (int c = 1; c < 700; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (glitch != 0 && c == glitch) begin
                start = 1'b1; src = ~src; dst = dst + 8'd7; len = 9'd3;
            end
            if (glitch != 0 && c == glitch + 1) start = 1'b0;
            if (e) begin
                if (obs_first_e < 0) obs_first_e = c;
                else if (last_e != c - 1) obs_gap++;
                last_e = c;
                obs_e++;
            end
            if (b) obs_busy++;
            if (f) begin
                obs_f++; seen_f = 1; obs_f_cycle = c;
`ifdef RAM_BLOCK_COPIER_CHECKSUM_EN
                obs_k = k_out;
`endif
            end
            if (seen_f && !b) begin obs_timeout = 0; break; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; src = 8'h5a; dst = 8'ha5; len = 9'd7;
        pre_we = 1'b0; pre_a = 8'd0; pre_d = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({q, a, d, e, b, f} !== 51'd0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h a=%h d=%h e=%b b=%b f=%b, want all 0", q, a, d, e, b, f);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (b !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b want 0", b); end
    endtask

    task automatic test_reset_mid_copy;
        int s, dd, n;
        fill_random;
        s = $urandom_range(0, 255); dd = $urandom_range(0, 255); n = 0;
        src = s[7:0]; dst = dd[7:0]; len = 9'd100; start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (e) n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({e, b, f} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_copy_outputs: e=%b b=%b f=%b want 000", e, b, f);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        begin
            int bad = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (b || f || e) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL reset_mid_copy_idle: %0d active cycles, want 0", bad); end
        end
        model_copy(s, dd, 100, n);
        checks++;
        if (n != 29) begin errors++; $display("FAIL reset_mid_copy_writes: %0d writes before reset, want 29", n); end
        checks++;
        if (ram_diff() != 0) begin errors++; $display("FAIL reset_mid_copy_ram: %0d words differ, want 0", ram_diff()); end
    endtask

    task automatic test_basic;
        fill_random;
        for (int i = 0; i < 4; i++) poke(8'h10 + i, i + 1);
        run_copy(8'h10, 8'h80, 4, 0);
        model_copy(8'h10, 8'h80, 4, 4);
        checks++;
        if (obs_timeout != 0) begin errors++; $display("FAIL basic_timeout: copy did not finish"); end
        checks++;
        if (obs_first_e != 2 || obs_e != 4 || obs_gap != 0) begin
            errors++;
            $display("FAIL basic_write_timing: first=%0d count=%0d gaps=%0d, want 2 4 0", obs_first_e, obs_e, obs_gap);
        end
        checks++;
        if (obs_f != 1 || obs_f_cycle != 6 || obs_busy != 6) begin
            errors++;
            $display("FAIL basic_done: pulses=%0d cycle=%0d busy=%0d, want 1 6 6", obs_f, obs_f_cycle, obs_busy);
        end
        checks++;
        if ({ram[8'h80], ram[8'h81], ram[8'h82], ram[8'h83]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
            errors++;
            $display("FAIL basic_dest: %0d %0d %0d %0d, want 1 2 3 4", ram[8'h80], ram[8'h81], ram[8'h82], ram[8'h83]);
        end
        checks++;
        if (ram_diff() != 0) begin errors++; $display("FAIL basic_ram: %0d words differ, want 0", ram_diff()); end
`ifdef RAM_BLOCK_COPIER_CHECKSUM_EN
        checks++;
        if (obs_k !== 32'd10) begin errors++; $display("FAIL basic_checksum: %0d want 10", obs_k); end
`endif
    endtask

    task automatic test_zero_len;
        run_copy($urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
        checks++;
        if (obs_timeout != 0 || obs_e != 0 || obs_f != 1 || obs_f_cycle != 1 || obs_busy != 1) begin
            errors++;
            $display("FAIL zero_len: to=%0d writes=%0d pulses=%0d cycle=%0d busy=%0d, want 0 0 1 1 1",
                     obs_timeout, obs_e, obs_f, obs_f_cycle, obs_busy);
        end
`ifdef RAM_BLOCK_COPIER_CHECKSUM_EN
        checks++;
        if (obs_k !== 32'd0) begin errors++; $display("FAIL zero_len_checksum: %0d want 0", obs_k); end
`endif
    endtask

    task automatic test_wrap;
        fill_random;
        run_copy(8'hfe, 8'h02, 4, 0);
        model_copy(8'hfe, 8'h02, 4, 4);
        checks++;
        if (obs_e != 4 || ram_diff() != 0 || ram[8'h04] !== ram[8'h00]) begin
            errors++; $display("FAIL wrap_src: writes=%0d diff=%0d, want 4 0", obs_e, ram_diff());
        end
        run_copy(8'h00, 8'hfe, 3, 0);
        model_copy(8'h00, 8'hfe, 3, 3);
        checks++;
        if (obs_e != 3 || ram_diff() != 0) begin
            errors++; $display("FAIL wrap_dst: writes=%0d diff=%0d, want 3 0", obs_e, ram_diff());
        end
    endtask

    task automatic test_overlap;
        logic [31:0] va, vb, vc, vd;
        va = $urandom; vb = $urandom; vc = $urandom; vd = $urandom;
        poke(8'h20, va); poke(8'h21, vb); poke(8'h22, vc); poke(8'h23, vd);
        run_copy(8'h20, 8'h21, 3, 0);
        model_copy(8'h20, 8'h21, 3, 3);
        checks++;
        if ({ram[8'h21], ram[8'h22], ram[8'h23]} !== {va, vb, vc} || ram_diff() != 0) begin
            errors++; $display("FAIL overlap_plus1: %h %h %h, want %h %h %h", ram[8'h21], ram[8'h22], ram[8'h23], va, vb, vc);
        end
        poke(8'h20, va); poke(8'h21, vb); poke(8'h22, vc); poke(8'h23, vd);
        run_copy(8'h20, 8'h22, 4, 0);
        model_copy(8'h20, 8'h22, 4, 4);
        checks++;
        if ({ram[8'h22], ram[8'h23], ram[8'h24], ram[8'h25]} !== {va, vb, va, vb} || ram_diff() != 0) begin
            errors++;
            $display("FAIL overlap_plus2: %h %h %h %h, want %h %h %h %h",
                     ram[8'h22], ram[8'h23], ram[8'h24], ram[8'h25], va, vb, va, vb);
        end
    endtask

    task automatic test_busy_start;
        int s, dd;
        fill_random;
        s = $urandom_range(0, 255); dd = $urandom_range(0, 255);
        run_copy(s, dd, 6, 3);
        model_copy(s, dd, 6, 6);
        checks++;
        if (obs_e != 6 || obs_f != 1 || obs_busy != 8 || ram_diff() != 0) begin
            errors++;
            $display("FAIL busy_start_ignored: writes=%0d pulses=%0d busy=%0d diff=%0d, want 6 1 8 0",
                     obs_e, obs_f, obs_busy, ram_diff());
        end
        s = $urandom_range(0, 255); dd = $urandom_range(0, 255);
        run_copy(s, dd, 5, 0);
        model_copy(s, dd, 5, 5);
        checks++;
        if (obs_e != 5 || obs_f != 1 || ram_diff() != 0) begin
            errors++; $display("FAIL busy_start_next: writes=%0d pulses=%0d diff=%0d, want 5 1 0", obs_e, obs_f, ram_diff());
        end
    endtask

    task automatic test_full;
        int s, dd;
        fill_random;
        s = $urandom_range(0, 255); dd = $urandom_range(0, 255);
        run_copy(s, dd, 256, 0);
        model_copy(s, dd, 256, 256);
        checks++;
        if (obs_timeout != 0 || obs_e != 256 || obs_gap != 0 || obs_f != 1 || obs_f_cycle != 258) begin
            errors++;
            $display("FAIL full_copy_timing: to=%0d writes=%0d gaps=%0d pulses=%0d cycle=%0d, want 0 256 0 1 258",
                     obs_timeout, obs_e, obs_gap, obs_f, obs_f_cycle);
        end
        checks++;
        if (ram_diff() != 0) begin errors++; $display("FAIL full_copy_ram: %0d words differ, want 0", ram_diff()); end
`ifdef RAM_BLOCK_COPIER_CHECKSUM_EN
        checks++;
        if (obs_k !== exp_sum) begin errors++; $display("FAIL full_copy_checksum: %h want %h", obs_k, exp_sum); end
`endif
    endtask

    task automatic test_random;
        int s, dd, l;
        fill_random;
        for (int t = 0; t < 8; t++) begin
            s = $urandom_range(0, 255);
            dd = (t % 2 == 0) ? ((s + $urandom_range(0, 6)) & 255) : $urandom_range(0, 255);
            l = $urandom_range(0, 40);
            run_copy(s, dd, l, 0);
            model_copy(s, dd, l, l);
            checks++;
            if (obs_timeout != 0 || obs_e != l || obs_f != 1 || obs_busy != ((l == 0) ? 1 : l + 2) || ram_diff() != 0) begin
                errors++;
                $display("FAIL random_copy_%0d: src=%0d dst=%0d len=%0d writes=%0d pulses=%0d busy=%0d diff=%0d",
                         t, s, dd, l, obs_e, obs_f, obs_busy, ram_diff());
            end
`ifdef RAM_BLOCK_COPIER_CHECKSUM_EN
            checks++;
            if (obs_k !== exp_sum) begin errors++; $display("FAIL random_checksum_%0d: %h want %h", t, obs_k, exp_sum); end
`endif
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_len;
        test_wrap;
        test_overlap;
        test_busy_start;
        test_full;
        test_random;
        test_reset_mid_copy;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
